// File: rtl/instr_mem_loadable_pkg.sv
// Shared types and defaults for the loadable instruction memory and its loader.
package instr_mem_loadable_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 256;

  // Replicated across the instruction width to form the fetch data reset value.
  localparam logic InstrRstBit = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StAssemble,
    StWrite,
    StDone
  } load_state_e;

endpackage

// File: rtl/instr_word_assembler.sv
// Collects a little-endian byte stream into one instruction word.
module instr_word_assembler #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_full_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);

  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    word_d      = word_q;
    idx_d       = idx_q;
    word_full_o = 1'b0;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_en_i) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (idx_q == IdxW'(b)) begin
          word_d[b*8 +: 8] = byte_i;
        end
      end
      // word_full_o flags the byte that completes the word; word_o is whole next cycle.
      if (idx_q == LastIdx) begin
        idx_d       = '0;
        word_full_o = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with registered fetch port and a byte-serial program loader.
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic              fetch_valid_o,
  output logic [DATA_W-1:0] instruccion_o,
  output logic              fetch_err_o,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              load_byte_valid_i,
  input  logic [7:0]        load_byte_i,
  output logic              load_byte_ready_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] InstrRst = {DATA_W{InstrRstBit}};

  logic [DATA_W-1:0] mem [DEPTH];

  load_state_e       state_q, state_d;
  // One bit wider than the address so a load running past the top never wraps into range.
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic              load_err_q, load_err_d;

  logic              fetch_valid_q;
  logic [DATA_W-1:0] instr_q;
  logic              fetch_err_q;

  logic              fetch_fire;
  logic              fetch_in_range;
  logic              asm_clear;
  logic              asm_byte_en;
  logic              asm_full;
  logic [DATA_W-1:0] asm_word;
  logic              mem_we;
  logic              byte_ready;
  logic              done_pulse;

  instr_word_assembler #(
    .DATA_W (DATA_W)
  ) u_assembler (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (asm_clear),
    .byte_en_i   (asm_byte_en),
    .byte_i      (load_byte_i),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  assign asm_byte_en = load_byte_valid_i && byte_ready;

  // Loader FSM next state and per-state controls.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    words_left_d = words_left_q;
    load_err_d   = load_err_q;
    asm_clear    = 1'b0;
    byte_ready   = 1'b0;
    mem_we       = 1'b0;
    done_pulse   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          wr_addr_d    = {1'b0, load_base_i};
          words_left_d = load_len_i;
          load_err_d   = 1'b0;
          asm_clear    = 1'b1;
          state_d      = (load_len_i == '0) ? StDone : StAssemble;
        end
      end
      StAssemble: begin
        byte_ready = 1'b1;
        if (asm_full) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wr_addr_q < DepthL) begin
          mem_we = 1'b1;
        end else begin
          load_err_d = 1'b1;
        end
        wr_addr_d    = wr_addr_q + (ADDR_W + 1)'(1);
        words_left_d = words_left_q - (ADDR_W + 1)'(1);
        state_d      = (words_left_q == (ADDR_W + 1)'(1)) ? StDone : StAssemble;
      end
      StDone: begin
        done_pulse = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      words_left_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      words_left_q <= words_left_d;
      load_err_q   <= load_err_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_addr_q[MemAw-1:0]] <= asm_word;
    end
  end

  // Fetch is only accepted in IDLE, so it never overlaps a write.
  assign fetch_ready_o  = !rst_i && (state_q == StIdle) && !load_start_i;
  assign fetch_fire     = fetch_req_i && fetch_ready_o;
  assign fetch_in_range = {1'b0, fetch_addr_i} < DepthL;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_valid_q <= 1'b0;
      instr_q       <= InstrRst;
      fetch_err_q   <= 1'b0;
    end else if (fetch_fire) begin
      fetch_valid_q <= 1'b1;
      if (fetch_in_range) begin
        instr_q     <= mem[fetch_addr_i[MemAw-1:0]];
        fetch_err_q <= 1'b0;
      end else begin
        instr_q     <= InstrRst;
        fetch_err_q <= 1'b1;
      end
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

  assign fetch_valid_o     = fetch_valid_q;
  assign instruccion_o     = instr_q;
  assign fetch_err_o       = fetch_err_q;
  assign load_byte_ready_o = byte_ready;
  assign load_busy_o       = (state_q != StIdle);
  assign load_done_o       = done_pulse;
  assign load_err_o        = load_err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable with DEPTH=200 to exercise the out-of-range paths.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] instruccion;
  logic        fetch_err;
  logic        load_start;
  logic [7:0]  load_base;
  logic [8:0]  load_len;
  logic        load_byte_valid;
  logic [7:0]  load_byte;
  logic        load_byte_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int passed = 0;
  int total  = 0;

  instr_mem_loadable #(
    .DATA_W (32),
    .ADDR_W (8),
    .DEPTH  (200)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .fetch_req_i       (fetch_req),
    .fetch_addr_i      (fetch_addr),
    .fetch_ready_o     (fetch_ready),
    .fetch_valid_o     (fetch_valid),
    .instruccion_o     (instruccion),
    .fetch_err_o       (fetch_err),
    .load_start_i      (load_start),
    .load_base_i       (load_base),
    .load_len_i        (load_len),
    .load_byte_valid_i (load_byte_valid),
    .load_byte_i       (load_byte),
    .load_byte_ready_o (load_byte_ready),
    .load_busy_o       (load_busy),
    .load_done_o       (load_done),
    .load_err_o        (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single fetch: checks latency-1 response and that data holds after valid drops.
  task automatic do_fetch(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                          input logic exp_e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    check({tag, "_ready"}, fetch_ready, 1);
    step();
    fetch_req = 1'b0;
    check({tag, "_valid"}, fetch_valid, 1);
    check({tag, "_err"}, fetch_err, exp_e);
    check({tag, "_data"}, instruccion, exp_d);
    step();
    check({tag, "_valid_drop"}, fetch_valid, 0);
    check({tag, "_hold"}, instruccion, exp_d);
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] len);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc = 1'b0;
    load_byte_valid = 1'b1;
    load_byte       = b;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = load_byte_ready;
      step();
    end
    load_byte_valid = 1'b0;
    check("byte_accept", acc, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v = w;
    for (int i = 0; i < 4; i++) send_byte(v[i*8 +: 8]);
  endtask

  task automatic wait_done(input string tag);
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (load_done) pulses++;
      step();
    end
    check({tag, "_done_pulses"}, pulses, 1);
    check({tag, "_busy_after"}, load_busy, 0);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_base = '0; load_len = '0; load_byte_valid = 1'b0; load_byte = '0;

    // Reset state.
    step();
    step();
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_instr", instruccion, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_fetch_ready", fetch_ready, 0);
    check("rst_byte_ready", load_byte_ready, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    rst = 1'b0;

    // Fetch with no load: only handshake/error checked, contents undefined.
    fetch_req  = 1'b1;
    fetch_addr = 8'h05;
    step();
    fetch_req = 1'b0;
    check("f05_valid", fetch_valid, 1);
    check("f05_err", fetch_err, 0);
    step();
    check("f05_valid_drop", fetch_valid, 0);

    // Two-word load at 0x10.
    start_load(8'h10, 9'd2);
    check("l10_busy", load_busy, 1);
    check("l10_byte_ready", load_byte_ready, 1);
    check("l10_fetch_ready", fetch_ready, 0);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    wait_done("l10");
    check("l10_err", load_err, 0);
    do_fetch("f10", 8'h10, 32'h1234_5678, 1'b0);
    do_fetch("f11", 8'h11, 32'hDEAD_BEEF, 1'b0);

    // Out-of-range fetches.
    do_fetch("fC8", 8'hC8, 32'h0, 1'b1);
    do_fetch("fFF", 8'hFF, 32'h0, 1'b1);

    // Load straddling the top: first word lands, second dropped with error.
    start_load(8'hC7, 9'd2);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    wait_done("lC7");
    check("lC7_err", load_err, 1);
    do_fetch("fC7", 8'hC7, 32'h4433_2211, 1'b0);
    check("lC7_err_sticky", load_err, 1);

    // load_start wins over a simultaneous fetch; start also clears the sticky error.
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    load_start = 1'b1;
    load_base  = 8'h12;
    load_len   = 9'd1;
    #1;
    check("prio_fetch_ready", fetch_ready, 0);
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("prio_no_valid", fetch_valid, 0);
    check("prio_busy", load_busy, 1);
    check("prio_err_cleared", load_err, 0);
    send_word(32'h0BAD_C0DE);
    wait_done("l12");

    // Zero-length load goes straight to DONE.
    start_load(8'h40, 9'd0);
    check("len0_done", load_done, 1);
    check("len0_busy", load_busy, 1);
    step();
    check("len0_done_drop", load_done, 0);
    check("len0_idle", load_busy, 0);

    // Reset mid-load after an error and two bytes of the third word.
    start_load(8'hC7, 9'd3);
    send_word(32'hDDCC_BBAA);
    send_word(32'h1111_1111);
    send_byte(8'h01);
    send_byte(8'h02);
    check("mid_err_before", load_err, 1);
    check("mid_busy_before", load_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy_after", load_busy, 0);
    check("mid_err_after", load_err, 0);
    check("mid_byte_ready", load_byte_ready, 0);
    do_fetch("fC7b", 8'hC7, 32'hDDCC_BBAA, 1'b0);

    // Bytes offered while idle are not consumed.
    load_byte_valid = 1'b1;
    load_byte       = 8'h5A;
    #1;
    check("idle_byte_ready", load_byte_ready, 0);
    step();
    load_byte_valid = 1'b0;
    check("idle_still_idle", load_busy, 0);

    // Back-to-back fetches.
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    step();
    fetch_addr = 8'h11;
    check("b2b0_valid", fetch_valid, 1);
    check("b2b0_data", instruccion, 32'h1234_5678);
    step();
    fetch_addr = 8'h12;
    check("b2b1_valid", fetch_valid, 1);
    check("b2b1_data", instruccion, 32'hDEAD_BEEF);
    step();
    fetch_req = 1'b0;
    check("b2b2_valid", fetch_valid, 1);
    check("b2b2_data", instruccion, 32'h0BAD_C0DE);
    check("b2b2_err", fetch_err, 0);
    step();
    check("b2b_valid_drop", fetch_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, synchronous successor to the combinational instruction ROM.
- Holds program words in an internal array and serves CPU fetches with a registered read, 1-cycle latency and a valid/error response.
- Adds a byte-serial program loader FSM that assembles little-endian words and writes them from a base address.
- Sits between the PC/fetch stage and the boot/UART loader path.

Parameters:
- DATA_W, 32: instruction width in bits; must be a multiple of 8.
- ADDR_W, 8: fetch/load word-address width.
- DEPTH, 256: number of words implemented; must satisfy DEPTH <= 2**ADDR_W.
- BYTES, DATA_W/8: derived localparam, bytes per word.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- fetch_req, in, 1: fetch request, accepted when fetch_ready=1.
- fetch_addr, in, ADDR_W: word address of the fetch.
- fetch_ready, out, 1: fetch port can accept a request.
- fetch_valid, out, 1: instruccion/fetch_err are valid this cycle.
- instruccion, out, DATA_W: fetched word.
- fetch_err, out, 1: fetched address was >= DEPTH.
- load_start, in, 1: begin a load (sampled only in IDLE).
- load_base, in, ADDR_W: first word address of the load.
- load_len, in, ADDR_W+1: number of words to load.
- load_byte_valid, in, 1: byte stream valid.
- load_byte, in, 8: byte stream data.
- load_byte_ready, out, 1: loader accepts a byte.
- load_busy, out, 1: loader active (not IDLE).
- load_done, out, 1: 1-cycle pulse when the load completes.
- load_err, out, 1: sticky flag; some load word targeted an address >= DEPTH.

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE; byte counter, word counter and assembly register clear.
  - Memory array contents are not reset.
  - Reset mid-load aborts the load. Words already written remain; the partial word is discarded and load_err clears.
- fetch_ready = (state==IDLE) && !load_start. load_start has priority over fetch in the same cycle.
- Fetch, on accepted fetch_req at cycle N:
  - fetch_valid=1 at N+1 for exactly one cycle.
  - If fetch_addr < DEPTH: instruccion=mem[fetch_addr], fetch_err=0.
  - Otherwise: instruccion=0, fetch_err=1.
  - Without an accepted request, fetch_valid=0 and instruccion/fetch_err hold their last values.
  - Back-to-back requests give back-to-back responses.
- FSM states: IDLE, ASSEMBLE, WRITE, DONE.
  - IDLE: on load_start, capture load_base into wr_addr and load_len into words_left, clear load_err and byte index, then go to ASSEMBLE. If load_len==0, go straight to DONE.
  - ASSEMBLE: load_byte_ready=1. Each load_byte_valid&&ready shifts the byte into lane byte_idx (little-endian: first byte goes to bits [7:0]). When the BYTES-th byte is accepted, go to WRITE.
  - WRITE (1 cycle): load_byte_ready=0.
    - If wr_addr < DEPTH, write mem[wr_addr]=assembled word. Otherwise drop the write and set load_err=1.
    - Increment wr_addr with no wrap. Use an ADDR_W+1-bit counter so addresses past 2**ADDR_W-1 stay out of range.
    - Decrement words_left. Go to DONE if it reaches 0, else to ASSEMBLE.
  - DONE (1 cycle): load_done=1, then go to IDLE. load_err holds until the next load_start or rst.
- load_busy=1 in ASSEMBLE, WRITE and DONE.
- Bytes offered while load_byte_ready=0 are not consumed. The loader never stalls internally except in WRITE.
- A fetch can never coincide with a write, so there is no read-during-write hazard.

Decomposition:
- Shared package:
  - FSM state enum: IDLE/ASSEMBLE/WRITE/DONE.
  - Constants DATA_W_DEF=32, ADDR_W_DEF=8, DEPTH_DEF=256.
  - Reset value for instruccion: all-zeros.
- One sub-module: instr_word_assembler (byte shifter plus byte_idx counter; outputs word and word_full).
- The memory array and fetch pipeline stay in the top level.

Test Plan:
- Reset then fetch addr 0x05 with no load -> fetch_valid at N+1, fetch_err=0; all outputs 0 during reset.
- Load base=0x10, len=2, bytes 78 56 34 12 EF BE AD DE -> load_done pulses once. Fetch 0x10 gives 0x12345678; fetch 0x11 gives 0xDEADBEEF at 1-cycle latency.
- DEPTH=200: fetch 0xC8 -> instruccion=0, fetch_err=1. Load base=0xC7, len=2 -> mem[0xC7] written, second word dropped, load_err=1 after done.
- load_start and fetch_req asserted in the same cycle -> fetch_ready=0, no fetch_valid; load proceeds. load_len=0 -> load_done on the next cycle.
- rst asserted after 2 bytes of the second word -> FSM IDLE, load_busy=0, first word retained, load_err=0.
- Back-to-back fetches to 0x10, 0x11, 0x12 -> three consecutive fetch_valid cycles with the matching data.
